tank_ctrl_param: RTL and testbench

//  Parametrised player-tank controller: grid movement, facing, fire-request generation, enemy-bullet hit detection.

---
 rtl/tank_ctrl_param_pkg.sv | 46 ++++
 rtl/tank_hit_detect.sv | 21 ++
 rtl/tank_ctrl_param.sv | 191 +++++++++++++++++++
 tb/tb_tank_ctrl_param.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_ctrl_param_pkg.sv
// Shared types for the player-tank controller.
// Direction and FSM encodings plus button-priority helper.
package tank_ctrl_param_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ALIVE = 2'b01,
        ST_HIT   = 2'b10,
        ST_DEAD  = 2'b11
    } state_t;

    typedef struct packed {
        logic vld;
        dir_t dir;
    } move_req_t;

    localparam int LIVES_W = 3;

    // Up beats down beats left beats right when several are held.
    function automatic move_req_t pick_dir(
        input logic w,
        input logic a,
        input logic s,
        input logic d
    );
        move_req_t r;
        r.vld = w | a | s | d;
        r.dir = DIR_UP;
        priority case (1'b1)
            w:       r.dir = DIR_UP;
            s:       r.dir = DIR_DOWN;
            a:       r.dir = DIR_LEFT;
            d:       r.dir = DIR_RIGHT;
            default: r.dir = DIR_UP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tank_hit_detect.sv
// Enemy-bullet overlap detector for the player tank.
// One comparator per bullet channel against the registered tank cell.
module tank_hit_detect #(
    parameter int COORD_W = 5,
    parameter int NUM_BUL = 4
) (
    input  logic [NUM_BUL*COORD_W-1:0] bul_x,
    input  logic [NUM_BUL*COORD_W-1:0] bul_y,
    input  logic [NUM_BUL-1:0]         bul_vld,
    input  logic [COORD_W-1:0]         x_pos,
    input  logic [COORD_W-1:0]         y_pos,
    output logic [NUM_BUL-1:0]         hit_raw
);

    for (genvar i = 0; i < NUM_BUL; i++) begin : g_cmp
        assign hit_raw[i] = bul_vld[i]
            && (bul_x[i*COORD_W +: COORD_W] == x_pos)
            && (bul_y[i*COORD_W +: COORD_W] == y_pos);
    end

endmodule

// File: rtl/tank_ctrl_param.sv
// Player-tank controller: movement, facing, fire requests,
// hit detection and the lives/respawn state machine.
module tank_ctrl_param
    import tank_ctrl_param_pkg::*;
#(
    parameter int COORD_W       = 5,
    parameter int GRID_W        = 20,
    parameter int GRID_H        = 15,
    parameter int NUM_BUL       = 4,
    parameter int LIVES         = 3,
    parameter int FIRE_CD       = 2,
    parameter int RESPAWN_TICKS = 8,
    parameter int START_X       = 10,
    parameter int START_Y       = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic                       tank_en,
    input  logic                       bt_w,
    input  logic                       bt_a,
    input  logic                       bt_s,
    input  logic                       bt_d,
    input  logic                       bt_st,
    input  logic [NUM_BUL*COORD_W-1:0] bul_x,
    input  logic [NUM_BUL*COORD_W-1:0] bul_y,
    input  logic [NUM_BUL-1:0]         bul_vld,
    output logic [COORD_W-1:0]         x_pos,
    output logic [COORD_W-1:0]         y_pos,
    output logic [1:0]                 tank_dir,
    output logic                       tank_state,
    output logic                       bul_sht,
    output logic [NUM_BUL-1:0]         hit_vec,
    output logic [LIVES_W-1:0]         lives,
    output logic                       game_over
);

    localparam int CD_W  = (FIRE_CD < 1) ? 1 : $clog2(FIRE_CD + 1);
    localparam int RSP_W = (RESPAWN_TICKS < 2) ? 1 : $clog2(RESPAWN_TICKS);

    localparam logic [COORD_W-1:0] SX     = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] SY     = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(GRID_H - 1);
    localparam logic [LIVES_W-1:0] LV_INI = LIVES_W'(LIVES);
    localparam logic [CD_W-1:0]    CD_INI = CD_W'(FIRE_CD);
    localparam logic [RSP_W-1:0]   RSP_END = RSP_W'(RESPAWN_TICKS - 1);

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    dir_t                 dir_q, dir_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [CD_W-1:0]      cd_q, cd_d;
    logic [RSP_W-1:0]     rsp_q, rsp_d;
    logic                 sht_q, sht_d;
    logic [NUM_BUL-1:0]   hv_q, hv_d;
    logic                 st_q;

    logic [NUM_BUL-1:0]   hit_raw;
    logic                 fire_edge;
    move_req_t            mv;

    tank_hit_detect #(
        .COORD_W (COORD_W),
        .NUM_BUL (NUM_BUL)
    ) u_hit (
        .bul_x   (bul_x),
        .bul_y   (bul_y),
        .bul_vld (bul_vld),
        .x_pos   (x_q),
        .y_pos   (y_q),
        .hit_raw (hit_raw)
    );

    assign fire_edge = bt_st & ~st_q;
    assign mv        = pick_dir(bt_w, bt_a, bt_s, bt_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= SX;
            y_q     <= SY;
            dir_q   <= DIR_UP;
            lives_q <= LV_INI;
            cd_q    <= '0;
            rsp_q   <= '0;
            sht_q   <= 1'b0;
            hv_q    <= '0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            lives_q <= lives_d;
            cd_q    <= cd_d;
            rsp_q   <= rsp_d;
            sht_q   <= sht_d;
            hv_q    <= hv_d;
            st_q    <= bt_st;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        lives_d = lives_q;
        cd_d    = cd_q;
        rsp_d   = rsp_q;
        sht_d   = 1'b0;
        hv_d    = '0;
        if (!tank_en) begin
            state_d = ST_IDLE;
            x_d     = SX;
            y_d     = SY;
            dir_d   = DIR_UP;
            lives_d = LV_INI;
            cd_d    = '0;
            rsp_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ALIVE;
                end
                ST_ALIVE: begin
                    if (|hit_raw) begin
                        // A hit pre-empts any move or shot this cycle.
                        state_d = ST_HIT;
                        hv_d    = hit_raw;
                        lives_d = lives_q - LIVES_W'(1);
                        x_d     = SX;
                        y_d     = SY;
                        dir_d   = DIR_UP;
                        cd_d    = '0;
                        rsp_d   = '0;
                    end else begin
                        if (tick && cd_q != '0)
                            cd_d = cd_q - CD_W'(1);
                        if (fire_edge && cd_q == '0) begin
                            sht_d = 1'b1;
                            cd_d  = CD_INI;
                        end
                        if (tick && mv.vld) begin
                            dir_d = mv.dir;
                            unique case (mv.dir)
                                DIR_UP:
                                    if (y_q != '0)
                                        y_d = y_q - COORD_W'(1);
                                DIR_DOWN:
                                    if (y_q < Y_MAX)
                                        y_d = y_q + COORD_W'(1);
                                DIR_LEFT:
                                    if (x_q != '0)
                                        x_d = x_q - COORD_W'(1);
                                DIR_RIGHT:
                                    if (x_q < X_MAX)
                                        x_d = x_q + COORD_W'(1);
                            endcase
                        end
                    end
                end
                ST_HIT: begin
                    if (tick) begin
                        if (rsp_q == RSP_END) begin
                            rsp_d   = '0;
                            state_d = (lives_q != '0) ? ST_ALIVE : ST_DEAD;
                        end else begin
                            rsp_d = rsp_q + RSP_W'(1);
                        end
                    end
                end
                ST_DEAD: begin
                    state_d = ST_DEAD;
                end
            endcase
        end
    end

    assign x_pos      = x_q;
    assign y_pos      = y_q;
    assign tank_dir   = dir_q;
    assign tank_state = (state_q == ST_ALIVE);
    assign bul_sht    = sht_q;
    assign hit_vec    = hv_q;
    assign lives      = lives_q;
    assign game_over  = (state_q == ST_DEAD);

endmodule

// File: tb/tb_tank_ctrl_param.sv
// Directed self-checking bench for tank_ctrl_param.
// Expected values are hand-derived constants.
module tb_tank_ctrl_param;

    localparam int CW = 5;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick;
    logic          tank_en;
    logic          bt_w, bt_a, bt_s, bt_d, bt_st;
    logic [NB*CW-1:0] bul_x, bul_y;
    logic [NB-1:0] bul_vld;
    logic [CW-1:0] x_pos, y_pos;
    logic [1:0]    tank_dir;
    logic          tank_state;
    logic          bul_sht;
    logic [NB-1:0] hit_vec;
    logic [2:0]    lives;
    logic          game_over;

    int n_chk  = 0;
    int n_fail = 0;

    tank_ctrl_param dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .tank_en    (tank_en),
        .bt_w       (bt_w),
        .bt_a       (bt_a),
        .bt_s       (bt_s),
        .bt_d       (bt_d),
        .bt_st      (bt_st),
        .bul_x      (bul_x),
        .bul_y      (bul_y),
        .bul_vld    (bul_vld),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .tank_dir   (tank_dir),
        .tank_state (tank_state),
        .bul_sht    (bul_sht),
        .hit_vec    (hit_vec),
        .lives      (lives),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic set_bul(input int ch, input int x, input int y);
        bul_x[ch*CW +: CW] = CW'(x);
        bul_y[ch*CW +: CW] = CW'(y);
    endtask

    task automatic check_spawn(input string tag);
        check({tag, "_x"}, int'(x_pos), 10);
        check({tag, "_y"}, int'(y_pos), 14);
        check({tag, "_dir"}, int'(tank_dir), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        tick    = 1'b0;
        tank_en = 1'b0;
        bt_w = 0; bt_a = 0; bt_s = 0; bt_d = 0; bt_st = 0;
        bul_x   = '0;
        bul_y   = '0;
        bul_vld = '0;
        repeat (3) step();

        check_spawn("rst");
        check("rst_state", int'(tank_state), 0);
        check("rst_lives", int'(lives), 3);
        check("rst_sht", int'(bul_sht), 0);
        check("rst_hv", int'(hit_vec), 0);
        check("rst_go", int'(game_over), 0);

        // tick during reset release is ignored
        tick  = 1'b1;
        rst_n = 1'b1;
        step();
        tick = 1'b0;
        check("rel_state", int'(tank_state), 0);
        tank_en = 1'b1;
        step();
        check("en_state", int'(tank_state), 1);
        check_spawn("en");
        check("en_lives", int'(lives), 3);

        // right to the edge and clamp
        bt_d = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            do_tick();
            check("mv_right_x", int'(x_pos), (10 + i > 19) ? 19 : 10 + i);
        end
        check("mv_right_dir", int'(tank_dir), 3);
        check("mv_right_y", int'(y_pos), 14);
        bt_w = 1'b1;
        do_tick();
        check("wd_dir", int'(tank_dir), 0);
        check("wd_y", int'(y_pos), 13);
        check("wd_x", int'(x_pos), 19);
        bt_w = 1'b0;
        bt_d = 1'b0;
        step();
        check("no_tick_y", int'(y_pos), 13);
        do_tick();
        check("idle_btn_x", int'(x_pos), 19);
        check("idle_btn_y", int'(y_pos), 13);
        bt_s = 1'b1;
        do_tick();
        check("down_dir", int'(tank_dir), 1);
        check("down_y", int'(y_pos), 14);
        do_tick();
        check("down_clamp_y", int'(y_pos), 14);
        bt_s = 1'b0;
        bt_w = 1'b1;
        do_tick();
        bt_w = 1'b0;
        check("up_y", int'(y_pos), 13);

        // fire, cooldown drop, fire again
        bt_st = 1'b1;
        step();
        check("fire1", int'(bul_sht), 1);
        step();
        check("fire1_pulse", int'(bul_sht), 0);
        bt_st = 1'b0;
        step();
        do_tick();
        bt_st = 1'b1;
        step();
        check("fire2_drop", int'(bul_sht), 0);
        step();
        check("fire2_drop_b", int'(bul_sht), 0);
        bt_st = 1'b0;
        step();
        do_tick();
        bt_st = 1'b1;
        step();
        check("fire3", int'(bul_sht), 1);
        bt_st = 1'b0;
        step();
        check("fire3_pulse", int'(bul_sht), 0);

        // two channels hit at (19,13)
        set_bul(0, 19, 13);
        set_bul(1, 19, 13);
        set_bul(2, 3, 3);
        set_bul(3, 19, 13);
        bul_vld = 4'b1010;
        step();
        check("hit_vec", int'(hit_vec), 10);
        check("hit_lives", int'(lives), 2);
        check("hit_state", int'(tank_state), 0);
        check_spawn("hit");
        bul_vld = 4'b0000;
        step();
        check("hit_vec_pulse", int'(hit_vec), 0);
        repeat (7) do_tick();
        check("rsp7_state", int'(tank_state), 0);
        do_tick();
        check("rsp8_state", int'(tank_state), 1);
        check("rsp8_lives", int'(lives), 2);

        // three hits with a bullet parked on spawn
        tank_en = 1'b0;
        step();
        check("dis_lives", int'(lives), 3);
        tank_en = 1'b1;
        step();
        set_bul(0, 10, 14);
        bul_vld = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step();
            check("multi_hv", int'(hit_vec), 1);
            check("multi_lives", int'(lives), 2 - k);
            repeat (4) do_tick();
            check("multi_inv_lives", int'(lives), 2 - k);
            check("multi_inv_hv", int'(hit_vec), 0);
            repeat (4) do_tick();
            if (k < 2)
                check("multi_alive", int'(tank_state), 1);
        end
        check("dead_go", int'(game_over), 1);
        check("dead_state", int'(tank_state), 0);
        check("dead_lives", int'(lives), 0);
        do_tick();
        check("dead_hold", int'(game_over), 1);
        bul_vld = 4'b0000;
        tank_en = 1'b0;
        step();
        check("dead_exit_go", int'(game_over), 0);
        check("dead_exit_lives", int'(lives), 3);
        check("dead_exit_state", int'(tank_state), 0);

        // hit coinciding with move and fire
        tank_en = 1'b1;
        step();
        set_bul(2, 10, 14);
        bul_vld = 4'b0100;
        tick  = 1'b1;
        bt_a  = 1'b1;
        bt_st = 1'b1;
        step();
        tick  = 1'b0;
        bt_a  = 1'b0;
        bt_st = 1'b0;
        bul_vld = 4'b0000;
        check("coin_hv", int'(hit_vec), 4);
        check("coin_sht", int'(bul_sht), 0);
        check("coin_lives", int'(lives), 2);
        check_spawn("coin");
        repeat (3) do_tick();
        rst_n   = 1'b0;
        tank_en = 1'b0;
        #1;
        check("arst_lives", int'(lives), 3);
        check("arst_state", int'(tank_state), 0);
        check("arst_go", int'(game_over), 0);
        check_spawn("arst");
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
